// File: rtl/accel_phase_driver.sv
// accel_phase_driver: one start pulse issues an AXI-Lite control write,
// then streams row_cnt x row_len generated beats on AXI-Stream.
module accel_phase_driver #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [31:0]         cmd_data,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    row_len,
  input  logic [CNT_W-1:0]    row_cnt,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [31:0]         m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                m_axis_tvalid,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tstrb,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [31:0] MASK = 32'h80200003;
  localparam logic [1:0] M_ROW   = 2'd0;
  localparam logic [1:0] M_INC   = 2'd1;
  localparam logic [1:0] M_LFSR  = 2'd2;
  localparam logic [1:0] M_CONST = 2'd3;

  typedef enum logic [2:0] {
    IDLE, CMD, RESP, STREAM, FIN
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0] mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic tvalid_q, tvalid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic last_beat;
  logic beat_fire;
  logic [DATA_W-1:0] pat;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? MASK : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] rep32(input logic [31:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      r[b*8 +: 8] = w[(b%4)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] row_pat(input logic [CNT_W-1:0] rw);
    logic [DATA_W-1:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      t = 32'(rw) * NB + b;
      r[b*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  assign last_beat = (row_q == cnt_q - ONE) && (col_q == len_q - ONE);
  assign beat_fire = tvalid_q && m_axis_tready;

  // Next-state, handshake tracking and counter advance.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mode_d    = mode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    beat_d    = beat_q;
    lfsr_d    = lfsr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = cmd_addr;
          data_d    = cmd_data;
          mode_d    = mode;
          len_d     = row_len;
          cnt_d     = row_cnt;
          col_d     = '0;
          row_d     = '0;
          beat_d    = '0;
          err_d     = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = CMD;
        end
      end
      CMD: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
        if ((!awvalid_q || m_axi_awready) &&
            (!wvalid_q || m_axi_wready)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (len_q == '0 || cnt_q == '0) begin
            state_d = FIN;
          end else begin
            lfsr_d  = LFSR_SEED;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (beat_fire) begin
          beat_d = beat_q + ONE;
          lfsr_d = lfsr_step(lfsr_q);
          if (col_q == len_q - ONE) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
          if (last_beat) state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bready_d = (state_d == RESP);
    tvalid_d = (state_d == STREAM);
    busy_d   = (state_d == CMD) || (state_d == RESP) ||
               (state_d == STREAM);
    done_d   = (state_d == FIN);
  end

  // Payload generator; gated so tdata reads zero outside a burst.
  always_comb begin
    pat = '0;
    unique case (mode_q)
      M_ROW:   pat = row_pat(row_q);
      M_INC:   pat = DATA_W'(beat_q);
      M_LFSR:  pat = rep32(lfsr_q);
      M_CONST: pat = rep32(data_q);
      default: pat = '0;
    endcase
  end

  // State, captured command and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      mode_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      beat_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      beat_q    <= beat_d;
      lfsr_q    <= lfsr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      tvalid_q  <= tvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tvalid_q ? pat : '0;
  assign m_axis_tstrb  = '1;
  assign m_axis_tlast  = tvalid_q && last_beat;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_accel_phase_driver.sv
// tb_accel_phase_driver: table of phases with a beat scoreboard,
// plus a mid-burst reset followed by an LFSR phase.
module tb_accel_phase_driver;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam logic [31:0] SEED = 32'h1;
  localparam logic [1:0] M_ROW   = 2'd0;
  localparam logic [1:0] M_INC   = 2'd1;
  localparam logic [1:0] M_LFSR  = 2'd2;
  localparam logic [1:0] M_CONST = 2'd3;

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [1:0] mode;
  logic [CW-1:0] row_len, row_cnt;
  logic [AW-1:0] awaddr;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic tvalid, tlast, tready;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic busy, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic [1:0]  mode;
    int          len;
    int          cnt;
    logic [31:0] data;
    logic [1:0]  bresp;
    int          aw_dly;
    int          w_dly;
    bit          toggle;
    bit          hold_start;
    bit          b_early;
    int          exp_beats;
    bit          exp_err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  accel_phase_driver dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .mode(mode),
    .row_len(row_len), .row_cnt(row_cnt),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .m_axis_tstrb(tstrb), .m_axis_tlast(tlast),
    .m_axis_tready(tready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  task automatic build_exp(input vec_t v);
    beat_t e;
    logic [31:0] lv;
    int rw;
    sb.delete();
    lv = SEED;
    for (int i = 0; i < v.exp_beats; i++) begin
      rw = i / v.len;
      case (v.mode)
        M_ROW:
          for (int b = 0; b < 4; b++)
            e.data[b*8 +: 8] = 8'((rw * 4 + b) % 256);
        M_INC:   e.data = 32'(i % 65536);
        M_LFSR:  e.data = lv;
        default: e.data = v.data;
      endcase
      e.last = (i == v.exp_beats - 1);
      sb.push_back(e);
      lv = lfsr_model(lv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tlast"}, tlast, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
  endtask

  task automatic run_phase(input vec_t v, input logic [31:0] addr,
                           input int abort_at);
    int cyc, aw_n, w_n, b_n, beats, aw_seen, w_seen, tog, done_cyc;
    bit got_done, stalled, viol;
    logic [DW-1:0] pd;
    logic pl;
    beat_t e;
    cyc = 0; aw_n = 0; w_n = 0; b_n = 0; beats = 0;
    aw_seen = 0; w_seen = 0; tog = 0; done_cyc = -1;
    got_done = 0; stalled = 0; viol = 0; pd = '0; pl = 0;
    build_exp(v);
    @(negedge clk);
    cmd_addr = addr;
    cmd_data = v.data;
    mode     = v.mode;
    row_len  = CW'(v.len);
    row_cnt  = CW'(v.cnt);
    bresp    = v.bresp;
    start    = 1'b1;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && beats == abort_at) begin
        chk("abort_tvalid_before", tvalid, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        start = 1'b0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; tready = 1'b0;
        sb.delete();
        return;
      end
      start = v.hold_start && busy;
      if (cyc == 1) begin
        chk("busy_rise", busy, 1);
        chk("aw_rise", awvalid, 1);
        chk("w_rise", wvalid, 1);
        chk("err_clear", err, 0);
      end
      if (bready && (awvalid || wvalid)) viol = 1;
      if (v.b_early) bvalid = (b_n == 0);
      else bvalid = (aw_n == 1 && w_n == 1 && b_n == 0);
      if (awvalid) aw_seen++;
      awready = awvalid && (aw_seen > v.aw_dly);
      if (awvalid && awready) begin
        aw_n++;
        chk("awaddr", awaddr, addr);
      end
      if (wvalid) w_seen++;
      wready = wvalid && (w_seen > v.w_dly);
      if (wvalid && wready) begin
        w_n++;
        chk("wdata", wdata, v.data);
        chk("wstrb", wstrb, 4'hF);
      end
      if (bvalid && bready) b_n++;
      if (tvalid) begin
        if (stalled) begin
          chk("stall_data", tdata, pd);
          chk("stall_last", tlast, pl);
        end
        tready = v.toggle ? (tog % 2 == 0) : 1'b1;
        tog++;
        if (tready) begin
          beats++;
          stalled = 0;
          if (sb.size() == 0) chk("extra_beat", 1, 0);
          else begin
            e = sb.pop_front();
            chk("tdata", tdata, e.data);
            chk("tlast", tlast, e.last);
            chk("tstrb", tstrb, 4'hF);
          end
        end else begin
          stalled = 1;
          pd = tdata;
          pl = tlast;
        end
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
        chk("err_at_done", err, v.exp_err);
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    chk("beats", beats, v.exp_beats);
    chk("sb_empty", sb.size(), 0);
    chk("aw_hs", aw_n, 1);
    chk("w_hs", w_n, 1);
    chk("b_hs", b_n, 1);
    chk("bready_only_resp", viol, 0);
    if (v.lat >= 0) chk("latency", done_cyc, v.lat);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_tvalid", tvalid, 0);
    chk("err_sticky", err, v.exp_err);
  endtask

  initial begin
    vec_t lv;
    vecs[0] = '{M_ROW, 48, 12, 32'h0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 576, 1'b0, 579};
    vecs[1] = '{M_INC, 3, 2, 32'h0, 2'b00, 0, 0, 1'b1, 1'b1, 1'b0, 6, 1'b0, -1};
    vecs[2] = '{M_INC, 2, 2, 32'h0, 2'b00, 3, 0, 1'b0, 1'b0, 1'b0, 4, 1'b0, -1};
    vecs[3] = '{M_CONST, 3, 2, 32'hDEADBEEF, 2'b00, 0, 5, 1'b0, 1'b0, 1'b0, 6, 1'b0, -1};
    vecs[4] = '{M_LFSR, 5, 4, 32'h0, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1};
    vecs[5] = '{M_INC, 2, 2, 32'h0, 2'b10, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 3};
    vecs[6] = '{M_INC, 2, 2, 32'h0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 7};
    vecs[7] = '{M_ROW, 4, 0, 32'h0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3};
    vecs[8] = '{M_ROW, 0, 3, 32'h0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3};
    vecs[9] = '{M_ROW, 1, 1, 32'h0, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 4};
    rst = 1'b1; start = 1'b0;
    cmd_addr = '0; cmd_data = '0; mode = '0;
    row_len = '0; row_cnt = '0;
    awready = 1'b0; wready = 1'b0;
    bresp = 2'b00; bvalid = 1'b0; tready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    chk("rst_wstrb", wstrb, 4'hF);
    chk("rst_tstrb", tstrb, 4'hF);
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      run_phase(vecs[i], 32'h4000_0000 + 32'(i * 4), 0);
    run_phase(vecs[0], 32'h5000_0000, 100);
    @(negedge clk);
    rst = 1'b0;
    lv = '{M_LFSR, 4, 5, 32'h0, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 20, 1'b0, -1};
    run_phase(lv, 32'h6000_0000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
